// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port 128-word synchronous RAM between
// instruction fetch and load/store, with one outstanding transaction at a time.
module imem_dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 7,
    parameter int DW     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DW-1:0]       i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DW-1:0]       d_wdata,
    input  logic [DW/8-1:0]     d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DW-1:0]       d_rdata,
    output logic                d_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DW/8-1:0]     mem_be,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic [DW-1:0]       mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t          state_reg, state_next;
    port_t           last_grant_reg, last_grant_next;
    port_t           served_reg, served_next;
    logic            err_reg, err_next;
    logic            store_reg, store_next;
    logic [DW-1:0]   i_rdata_reg;
    logic [DW-1:0]   d_rdata_reg;

    logic            i_bad, d_bad;
    logic            grant_ok, pick_i, pick_d;

    // Bad requests are still granted and answered, they just never touch memory.
    assign i_bad = (i_addr[1:0] != 2'b00) || (i_addr[ADDR_W-1:MEM_AW+2] != '0);
    assign d_bad = (d_addr[ADDR_W-1:MEM_AW+2] != '0)
                || (!d_we && (d_addr[1:0] != 2'b00))
                || (d_we && (d_be == '0));

    // Gating with reset_n keeps the grant outputs low while reset is held.
    assign grant_ok = reset_n && ((state_reg == ST_IDLE) || (state_reg == ST_RESP));
    assign pick_i   = grant_ok && i_req && (!d_req || (last_grant_reg == PORT_D));
    assign pick_d   = grant_ok && d_req && (!i_req || (last_grant_reg == PORT_I));

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        served_next     = served_reg;
        err_next        = err_reg;
        store_next      = store_reg;
        i_gnt           = 1'b0;
        d_gnt           = 1'b0;
        mem_en          = 1'b0;
        mem_we          = 1'b0;
        mem_be          = '0;
        mem_addr        = '0;
        mem_wdata       = '0;

        if (state_reg == ST_WAIT) begin
            state_next = ST_RESP;
        end else if (pick_i) begin
            i_gnt           = 1'b1;
            state_next      = ST_WAIT;
            last_grant_next = PORT_I;
            served_next     = PORT_I;
            err_next        = i_bad;
            store_next      = 1'b0;
            mem_en          = !i_bad;
            mem_addr        = i_addr[MEM_AW+1:2];
        end else if (pick_d) begin
            d_gnt           = 1'b1;
            state_next      = ST_WAIT;
            last_grant_next = PORT_D;
            served_next     = PORT_D;
            err_next        = d_bad;
            store_next      = d_we;
            mem_en          = !d_bad;
            mem_we          = d_we && !d_bad;
            mem_be          = d_be;
            mem_addr        = d_addr[MEM_AW+1:2];
            mem_wdata       = d_wdata;
        end else begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= PORT_D;
            served_reg     <= PORT_I;
            err_reg        <= 1'b0;
            store_reg      <= 1'b0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            served_reg     <= served_next;
            err_reg        <= err_next;
            store_reg      <= store_next;
            // Capture read data at the end of WAIT; errors and stores keep the old value.
            if ((state_reg == ST_WAIT) && !err_reg) begin
                if (served_reg == PORT_I) begin
                    i_rdata_reg <= mem_rdata;
                end else if (!store_reg) begin
                    d_rdata_reg <= mem_rdata;
                end
            end
        end
    end

    assign i_rvalid = (state_reg == ST_RESP) && (served_reg == PORT_I);
    assign d_rvalid = (state_reg == ST_RESP) && (served_reg == PORT_D);
    assign i_err    = i_rvalid && err_reg;
    assign d_err    = d_rvalid && err_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of the arbiter and memory.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_dmem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: registered read, byte-enabled write, plus a preload port.
    logic [31:0] tb_mem [128];
    logic        ld_en = 1'b0;
    logic [6:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    always @(posedge clk) begin
        if (ld_en) begin
            tb_mem[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [128];
    bit          outst;
    int          cyc;
    int          resp_cyc;
    bit          resp_port;      // 0 = fetch, 1 = data
    bit          resp_err;
    bit          resp_store;
    logic [31:0] resp_addr;
    logic [31:0] resp_data;
    bit          last_d;         // last grant went to data
    logic [31:0] exp_irdata, exp_drdata;
    bit          last_gi, last_gd;
    int          n_ig, n_dg, n_both;

    function automatic bit addr_bad(input logic [31:0] a, input bit is_data,
                                    input bit we, input logic [3:0] be);
        if (a >= 32'd512) return 1'b1;
        if (is_data && we) return (be == 4'd0);
        return (a % 4) != 0;
    endfunction

    // One clock: inputs are stable at the falling edge, where everything is compared.
    task automatic cycle();
        bit rnow, opp, gi, gd, bad, exp_en;
        logic [31:0] a;
        int idx;
        @(negedge clk);
        rnow = outst && (cyc == resp_cyc);
        opp  = !outst || rnow;
        if (rnow) begin
            if (!resp_err && !resp_store) begin
                if (resp_port) exp_drdata = resp_data;
                else           exp_irdata = resp_data;
            end
            $display("cyc %0d resp %s addr=%08h store=%0d err=%0d data=%08h", cyc,
                     resp_port ? "D" : "I", resp_addr, resp_store, resp_err,
                     resp_port ? exp_drdata : exp_irdata);
        end
        check("i_rvalid", {31'b0, i_rvalid}, {31'b0, rnow && !resp_port});
        check("d_rvalid", {31'b0, d_rvalid}, {31'b0, rnow && resp_port});
        check("i_err", {31'b0, i_err}, {31'b0, rnow && !resp_port && resp_err});
        check("d_err", {31'b0, d_err}, {31'b0, rnow && resp_port && resp_err});
        check("i_rdata", i_rdata, exp_irdata);
        check("d_rdata", d_rdata, exp_drdata);

        gi = opp && i_req && (!d_req || last_d);
        gd = opp && d_req && (!i_req || !last_d);
        check("i_gnt", {31'b0, i_gnt}, {31'b0, gi});
        check("d_gnt", {31'b0, d_gnt}, {31'b0, gd});
        n_ig   += int'(i_gnt);
        n_dg   += int'(d_gnt);
        n_both += int'(i_gnt && d_gnt);

        a   = gd ? d_addr : i_addr;
        bad = gd ? addr_bad(d_addr, 1'b1, d_we, d_be) : addr_bad(i_addr, 1'b0, 1'b0, 4'd0);
        exp_en = (gi || gd) && !bad;
        check("mem_en", {31'b0, mem_en}, {31'b0, exp_en});
        check("mem_we", {31'b0, mem_we}, {31'b0, exp_en && gd && d_we});
        if (exp_en) begin
            check("mem_addr", {25'b0, mem_addr}, a / 4);
            if (gd) check("mem_be", {28'b0, mem_be}, {28'b0, d_be});
            if (gd && d_we) check("mem_wdata", mem_wdata, d_wdata);
        end

        if (gi || gd) begin
            outst      = 1'b1;
            resp_cyc   = cyc + 2;
            resp_port  = gd;
            resp_err   = bad;
            resp_store = gd && d_we;
            resp_addr  = a;
            if (!bad) begin
                idx = int'(a / 4);
                resp_data = ref_mem[idx];
                if (gd && d_we)
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) ref_mem[idx][8*b +: 8] = d_wdata[8*b +: 8];
            end
            last_d = gd;
        end else if (rnow) begin
            outst = 1'b0;
        end
        last_gi = gi;
        last_gd = gd;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns before the next falling edge.
    task automatic do_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst i_gnt", {31'b0, i_gnt}, 32'd0);
        check("rst d_gnt", {31'b0, d_gnt}, 32'd0);
        check("rst i_rvalid", {31'b0, i_rvalid}, 32'd0);
        check("rst d_rvalid", {31'b0, d_rvalid}, 32'd0);
        check("rst i_err", {31'b0, i_err}, 32'd0);
        check("rst d_err", {31'b0, d_err}, 32'd0);
        check("rst mem_en", {31'b0, mem_en}, 32'd0);
        check("rst mem_we", {31'b0, mem_we}, 32'd0);
        check("rst mem_addr", {25'b0, mem_addr}, 32'd0);
        check("rst mem_be", {28'b0, mem_be}, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst i_rdata", i_rdata, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        outst = 1'b0;
        last_d = 1'b1;
        exp_irdata = '0;
        exp_drdata = '0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] a);
        i_req = 1'b1;
        i_addr = a;
        cycle();
        i_req = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic data_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        d_be = be;
        cycle();
        d_req = 1'b0;
        cycle();
        cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return $urandom | 32'h200;
        return 32'($urandom_range(0, 127)) << 2;
    endfunction

    task automatic rand_data();
        d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr();
        d_wdata = $urandom;
        d_be = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    endtask

    initial begin
        reset_n = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        cyc = 0; outst = 1'b0; last_d = 1'b1;
        n_ig = 0; n_dg = 0; n_both = 0;
        for (int k = 0; k < 128; k++) ref_mem[k] = $urandom;
        ref_mem[0] = 32'h00500113;
        ref_mem[4] = 32'h11223344;
        @(posedge clk);
        #1;
        for (int k = 0; k < 128; k++) begin
            ld_en = 1'b1;
            ld_addr = 7'(k);
            ld_data = ref_mem[k];
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        do_reset();

        // Single fetch right after reset
        fetch(32'h0);
        check("fetch word0", i_rdata, 32'h00500113);

        // Store then load
        data_op(1'b1, 32'h60, 32'd7, 4'hF);
        data_op(1'b0, 32'h60, 32'd0, 4'hF);
        check("load after store", d_rdata, 32'd7);

        // Byte-lane store and readback
        data_op(1'b1, 32'h10, 32'h0000AA00, 4'h2);
        data_op(1'b0, 32'h10, 32'd0, 4'hF);
        check("byte store readback", d_rdata, 32'h1122AA44);

        // Both requesters held: grants alternate I, D, I, D
        n_ig = 0; n_dg = 0; n_both = 0;
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; d_be = 4'hF;
        for (int k = 0; k < 8; k++) cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        check("contend i grants", n_ig, 32'd2);
        check("contend d grants", n_dg, 32'd2);
        check("contend both high", n_both, 32'd0);
        for (int k = 0; k < 3; k++) cycle();

        // Error cases
        fetch(32'h2);
        data_op(1'b0, 32'h200, 32'd0, 4'hF);
        data_op(1'b1, 32'h40, 32'hDEADBEEF, 4'h0);

        // Reset while a fetch sits in WAIT
        i_req = 1'b1;
        i_addr = 32'h8;
        cycle();
        do_reset();
        for (int k = 0; k < 3; k++) cycle();
        fetch(32'h0);
        check("fetch after reset", i_rdata, 32'h00500113);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if (i_req) begin
                if (last_gi) begin
                    if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                    else i_addr = rand_addr();
                end else if ($urandom_range(0, 19) == 0) begin
                    i_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                i_addr = rand_addr();
            end
            if (d_req) begin
                if (last_gd) begin
                    if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                    else rand_data();
                end else if ($urandom_range(0, 19) == 0) begin
                    d_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                rand_data();
            end
            cycle();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
